// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I pipeline constants and types
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - pipeline register with load, hold and flush-to-NOP
module if_id_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc4_d,
  input  logic [31:0]     instr_d,
  output logic            valid_q,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc4_q,
  output logic [31:0]     instr_q
);
  import rv32_pkg::*;

  // Hold is the default: contents change only on load or flush, flush winning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, imem req/ack FSM, IF/ID load
// Optional FETCH_PERF_CNT_EN adds fetch/flush counters.
module fetch_stage #(
  parameter int              XLEN     = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv32_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     flush_cnt_o,
`endif
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [31:0]     if_id_instr_o
);
  import rv32_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_tgt;
  logic [31:0]     skid_instr;
  logic            redirect_take;
  logic            ifid_load;
  logic [31:0]     ifid_instr_d;
  logic            unused_redirect_lsbs;

  assign pc_plus4             = pc + XLEN'(4);
  assign redirect_tgt         = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign redirect_take        = redirect_i && (state != IDLE);

  assign ifid_load = !redirect_take && !stall_i &&
                     (((state == FETCH) && imem_ack_i) || (state == HOLD));
  assign ifid_instr_d = (state == HOLD) ? skid_instr : imem_rdata_i;

  assign imem_req_o  = (state == FETCH);
  assign imem_addr_o = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      skid_instr <= NOP_INSTR;
    end else if (redirect_take) begin
      pc         <= redirect_tgt;
      skid_instr <= NOP_INSTR;
      // An unacked request still owes us a response that must be swallowed.
      if (((state == FETCH) || (state == DRAIN)) && !imem_ack_i)
        state <= DRAIN;
      else
        state <= FETCH;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack_i) begin
            if (stall_i) begin
              skid_instr <= imem_rdata_i;
              state      <= HOLD;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack_i)
            state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .flush   (redirect_take),
    .pc_d    (pc),
    .pc4_d   (pc_plus4),
    .instr_d (ifid_instr_d),
    .valid_q (if_id_valid_o),
    .pc_q    (if_id_pc_o),
    .pc4_q   (if_id_pc4_o),
    .instr_q (if_id_instr_o)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (ifid_load)
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (redirect_take)
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
